// File: rtl/pc_fetch.sv
// pc_fetch: Hack CPU program counter and instruction-fetch stage (fetch -> issue -> execute -> update).
// Define BREAKPOINT_EN to add a PC breakpoint that parks the stage before fetching bp_addr.
module pc_fetch #(
    parameter int                ADDR_W   = 15,
    parameter int                DATA_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              upd_valid,
    input  logic              load,
    input  logic              inc,
    input  logic [ADDR_W-1:0] a_reg,
`ifdef BREAKPOINT_EN
    input  logic              bp_en,
    input  logic [ADDR_W-1:0] bp_addr,
    input  logic              bp_resume,
    output logic              bp_hit,
`endif
    output logic [ADDR_W-1:0] pc
);

    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        EXEC
`ifdef BREAKPOINT_EN
        , BREAK
`endif
    } state_t;

    state_t              state, state_d;
    logic [ADDR_W-1:0]   pc_d;
    logic [ADDR_W-1:0]   pc_target;
    logic                req_d;
    logic                valid_d;
    logic [DATA_W-1:0]   instr_d;
    logic [ADDR_W-1:0]   instr_pc_d;
`ifdef BREAKPOINT_EN
    logic                hit_d;
    logic                stop_at_pc;
    logic                stop_at_target;
`endif

    assign imem_addr = pc;

    // Load has priority over inc; neither means refetch the same address.
    assign pc_target = load ? a_reg : (inc ? pc + ADDR_W'(1) : pc);

`ifdef BREAKPOINT_EN
    assign stop_at_pc     = bp_en && (pc == bp_addr);
    assign stop_at_target = bp_en && (pc_target == bp_addr);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
`ifdef BREAKPOINT_EN
            bp_hit      <= 1'b0;
`endif
        end else begin
            state       <= state_d;
            pc          <= pc_d;
            imem_req    <= req_d;
            instr_valid <= valid_d;
            instr       <= instr_d;
            instr_pc    <= instr_pc_d;
`ifdef BREAKPOINT_EN
            bp_hit      <= hit_d;
`endif
        end
    end

    // FETCH with imem_req low only occurs on the first cycle out of reset.
    always_comb begin
        state_d    = state;
        pc_d       = pc;
        req_d      = imem_req;
        valid_d    = instr_valid;
        instr_d    = instr;
        instr_pc_d = instr_pc;
`ifdef BREAKPOINT_EN
        hit_d      = bp_hit;
`endif
        case (state)
            FETCH: begin
                if (!imem_req) begin
`ifdef BREAKPOINT_EN
                    if (stop_at_pc) begin
                        state_d = BREAK;
                        hit_d   = 1'b1;
                    end else
`endif
                    req_d = 1'b1;
                end else if (imem_ack) begin
                    instr_d    = imem_rdata;
                    instr_pc_d = pc;
                    valid_d    = 1'b1;
                    req_d      = 1'b0;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                if (instr_ready) begin
                    valid_d = 1'b0;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (upd_valid) begin
                    pc_d = pc_target;
`ifdef BREAKPOINT_EN
                    if (stop_at_target) begin
                        state_d = BREAK;
                        hit_d   = 1'b1;
                    end else
`endif
                    begin
                        state_d = FETCH;
                        req_d   = 1'b1;
                    end
                end
            end
`ifdef BREAKPOINT_EN
            // Resuming fetches bp_addr without re-checking the breakpoint.
            BREAK: begin
                if (bp_resume) begin
                    hit_d   = 1'b0;
                    req_d   = 1'b1;
                    state_d = FETCH;
                end
            end
`endif
            default: state_d = FETCH;
        endcase
    end

endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: scoreboard bench for pc_fetch; expected fetch addresses and instructions are queued
// as stimulus is driven and popped when the DUT presents them. Breakpoint test needs BREAKPOINT_EN.
module tb_pc_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [14:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_rdata = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [15:0] instr;
    logic [14:0] instr_pc;
    logic        upd_valid = 1'b0;
    logic        load = 1'b0;
    logic        inc = 1'b0;
    logic [14:0] a_reg = '0;
    logic [14:0] pc;
`ifdef BREAKPOINT_EN
    logic        bp_en = 1'b0;
    logic [14:0] bp_addr = '0;
    logic        bp_resume = 1'b0;
    logic        bp_hit;
`endif

    pc_fetch #(.ADDR_W(15), .DATA_W(16), .RESET_PC(15'h0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
        .upd_valid(upd_valid), .load(load), .inc(inc), .a_reg(a_reg),
`ifdef BREAKPOINT_EN
        .bp_en(bp_en), .bp_addr(bp_addr), .bp_resume(bp_resume), .bp_hit(bp_hit),
`endif
        .pc(pc)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        int          ack_dly;
        int          rdy_dly;
        logic [15:0] rdata;
        logic        ld;
        logic        ic;
        logic [14:0] a;
    } stim_t;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [14:0] model_pc;
    logic [14:0] addr_q[$];
    logic [15:0] instr_q[$];
    logic [14:0] ipc_q[$];

    logic [14:0] obs_addr, exp_addr, obs_ipc, exp_ipc;
    logic [15:0] obs_instr, exp_instr;
    bit          req_seen, stable_ok, lat_ok;

    function automatic logic [14:0] model_next(input logic [14:0] p, input logic ld, input logic ic,
                                               input logic [14:0] a);
        if (ld) return a;
        if (ic) return p + 15'd1;
        return p;
    endfunction

    task automatic sb_reset();
        addr_q.delete();
        instr_q.delete();
        ipc_q.delete();
        model_pc = 15'h0000;
        addr_q.push_back(model_pc);
    endtask

    // Drives one full fetch/issue/update transaction and records observed vs scoreboard values.
    task automatic run_instr(input stim_t s);
        req_seen  = 1'b0;
        stable_ok = 1'b1;
        lat_ok    = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (imem_req === 1'b1) begin
                req_seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        obs_addr = imem_addr;
        exp_addr = (addr_q.size() > 0) ? addr_q.pop_front() : 15'hxxxx;
        if (!req_seen) return;
        repeat (s.ack_dly) begin
            @(posedge clk); #1;
            if (imem_req !== 1'b1 || imem_addr !== obs_addr || instr_valid !== 1'b0) stable_ok = 1'b0;
        end
        imem_ack   = 1'b1;
        imem_rdata = s.rdata;
        instr_q.push_back(s.rdata);
        ipc_q.push_back(model_pc);
        @(posedge clk); #1;
        imem_ack   = 1'b0;
        imem_rdata = 16'($urandom);
        if (instr_valid !== 1'b1 || imem_req !== 1'b0) lat_ok = 1'b0;
        obs_instr = instr;
        obs_ipc   = instr_pc;
        exp_instr = (instr_q.size() > 0) ? instr_q.pop_front() : 16'hxxxx;
        exp_ipc   = (ipc_q.size() > 0) ? ipc_q.pop_front() : 15'hxxxx;
        repeat (s.rdy_dly) begin
            @(posedge clk); #1;
            if (instr_valid !== 1'b1 || instr !== obs_instr || instr_pc !== obs_ipc) stable_ok = 1'b0;
        end
        instr_ready = 1'b1;
        @(posedge clk); #1;
        instr_ready = 1'b0;
        if (instr_valid !== 1'b0) lat_ok = 1'b0;
        upd_valid = 1'b1;
        load      = s.ld;
        inc       = s.ic;
        a_reg     = s.a;
        model_pc  = model_next(model_pc, s.ld, s.ic, s.a);
        addr_q.push_back(model_pc);
        @(posedge clk); #1;
        upd_valid = 1'b0;
        load      = 1'b0;
        inc       = 1'b0;
        a_reg     = 15'($urandom);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_checks++; if (pc !== 15'h0000) $display("[TB] FAIL reset_pc: got %h expected 0000", pc); else n_pass++;
        n_checks++; if (imem_req !== 1'b0) $display("[TB] FAIL reset_req: got %b expected 0", imem_req); else n_pass++;
        n_checks++; if (instr_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", instr_valid); else n_pass++;
        n_checks++; if (instr !== 16'h0000 || instr_pc !== 15'h0000)
            $display("[TB] FAIL reset_instr: got %h/%h expected 0000/0000", instr, instr_pc); else n_pass++;
        sb_reset();
        @(negedge clk);
        rst_n      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 16'hDEAD;
        @(posedge clk); #1;
        imem_ack = 1'b0;
        n_checks++; if (imem_req !== 1'b1) $display("[TB] FAIL first_req: got %b expected 1", imem_req); else n_pass++;
        n_checks++; if (instr_valid !== 1'b0) $display("[TB] FAIL early_ack_ignored: got valid %b expected 0", instr_valid); else n_pass++;
    endtask

    task automatic test_sequential();
        stim_t tbl[3] = '{'{0, 0, 16'h0010, 1'b0, 1'b1, 15'h0000},
                          '{0, 0, 16'h0011, 1'b0, 1'b1, 15'h0000},
                          '{0, 0, 16'hA5A5, 1'b0, 1'b1, 15'h0000}};
        for (int i = 0; i < 3; i++) begin
            run_instr(tbl[i]);
            n_checks++; if (!req_seen || !lat_ok) $display("[TB] FAIL seq_handshake[%0d]: got req %b lat %b expected 1 1", i, req_seen, lat_ok); else n_pass++;
            n_checks++; if (obs_addr !== exp_addr) $display("[TB] FAIL seq_addr[%0d]: got %h expected %h", i, obs_addr, exp_addr); else n_pass++;
            n_checks++; if (obs_instr !== exp_instr || obs_ipc !== exp_ipc)
                $display("[TB] FAIL seq_instr[%0d]: got %h@%h expected %h@%h", i, obs_instr, obs_ipc, exp_instr, exp_ipc); else n_pass++;
            n_checks++; if (pc !== model_pc || imem_req !== 1'b1 || imem_addr !== model_pc)
                $display("[TB] FAIL seq_update[%0d]: got pc %h req %b expected pc %h req 1", i, pc, imem_req, model_pc); else n_pass++;
        end
    endtask

    task automatic test_jump();
        stim_t tbl[4] = '{'{0, 0, 16'h1000, 1'b1, 1'b0, 15'h0005},
                          '{1, 0, 16'h1001, 1'b1, 1'b0, 15'h0123},
                          '{0, 1, 16'h1002, 1'b1, 1'b1, 15'h0123},
                          '{0, 0, 16'h1003, 1'b0, 1'b1, 15'h0456}};
        for (int i = 0; i < 4; i++) begin
            run_instr(tbl[i]);
            n_checks++; if (obs_addr !== exp_addr) $display("[TB] FAIL jump_addr[%0d]: got %h expected %h", i, obs_addr, exp_addr); else n_pass++;
            n_checks++; if (obs_ipc !== exp_ipc) $display("[TB] FAIL jump_instr_pc[%0d]: got %h expected %h", i, obs_ipc, exp_ipc); else n_pass++;
            n_checks++; if (pc !== model_pc || imem_addr !== model_pc || imem_req !== 1'b1)
                $display("[TB] FAIL jump_update[%0d]: got pc %h req %b expected pc %h req 1", i, pc, imem_req, model_pc); else n_pass++;
        end
    endtask

    task automatic test_wrap();
        stim_t tbl[4] = '{'{0, 0, 16'h2000, 1'b1, 1'b0, 15'h7FFF},
                          '{0, 0, 16'h2001, 1'b0, 1'b1, 15'h1111},
                          '{0, 0, 16'h2002, 1'b0, 1'b0, 15'h2222},
                          '{0, 0, 16'h2003, 1'b0, 1'b1, 15'h3333}};
        for (int i = 0; i < 4; i++) begin
            run_instr(tbl[i]);
            n_checks++; if (obs_addr !== exp_addr || obs_instr !== exp_instr)
                $display("[TB] FAIL wrap_fetch[%0d]: got %h:%h expected %h:%h", i, obs_addr, obs_instr, exp_addr, exp_instr); else n_pass++;
            n_checks++; if (pc !== model_pc) $display("[TB] FAIL wrap_pc[%0d]: got %h expected %h", i, pc, model_pc); else n_pass++;
        end
    endtask

    task automatic test_stall();
        stim_t tbl[2] = '{'{3, 2, 16'h0000, 1'b0, 1'b1, 15'h0000},
                          '{2, 3, 16'h0000, 1'b1, 1'b0, 15'h0ABC}};
        for (int i = 0; i < 2; i++) begin
            tbl[i].rdata = 16'($urandom);
            run_instr(tbl[i]);
            n_checks++; if (!stable_ok || !lat_ok) $display("[TB] FAIL stall_stable[%0d]: got stable %b lat %b expected 1 1", i, stable_ok, lat_ok); else n_pass++;
            n_checks++; if (obs_instr !== exp_instr || obs_addr !== exp_addr)
                $display("[TB] FAIL stall_fetch[%0d]: got %h:%h expected %h:%h", i, obs_addr, obs_instr, exp_addr, exp_instr); else n_pass++;
            n_checks++; if (pc !== model_pc) $display("[TB] FAIL stall_pc[%0d]: got %h expected %h", i, pc, model_pc); else n_pass++;
        end
    endtask

    task automatic test_reset_in_hold();
        stim_t s = '{0, 0, 16'h0001, 1'b1, 1'b0, 15'h0042};
        bit seen = 1'b0;
        run_instr(s);
        for (int i = 0; i < 20; i++) begin
            if (imem_req === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        exp_addr = (addr_q.size() > 0) ? addr_q.pop_front() : 15'hxxxx;
        n_checks++; if (!seen || imem_addr !== exp_addr) $display("[TB] FAIL hold_fetch: got req %b addr %h expected 1 %h", seen, imem_addr, exp_addr); else n_pass++;
        imem_ack   = 1'b1;
        imem_rdata = 16'h1234;
        @(posedge clk); #1;
        imem_ack   = 1'b1;
        imem_rdata = 16'hBEEF;
        upd_valid  = 1'b1;
        load       = 1'b1;
        a_reg      = 15'h0055;
        @(posedge clk); #1;
        imem_ack  = 1'b0;
        upd_valid = 1'b0;
        load      = 1'b0;
        n_checks++; if (instr_valid !== 1'b1 || instr !== 16'h1234)
            $display("[TB] FAIL hold_stray_ack: got valid %b instr %h expected 1 1234", instr_valid, instr); else n_pass++;
        n_checks++; if (pc !== 15'h0042 || imem_req !== 1'b0)
            $display("[TB] FAIL hold_stray_upd: got pc %h req %b expected 0042 0", pc, imem_req); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (instr_valid !== 1'b0 || pc !== 15'h0000 || imem_req !== 1'b0)
            $display("[TB] FAIL hold_async_reset: got valid %b pc %h req %b expected 0 0000 0", instr_valid, pc, imem_req); else n_pass++;
        sb_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        exp_addr = addr_q.pop_front();
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== exp_addr)
            $display("[TB] FAIL hold_restart: got req %b addr %h expected 1 %h", imem_req, imem_addr, exp_addr); else n_pass++;
    endtask

`ifdef BREAKPOINT_EN
    task automatic test_breakpoint();
        stim_t s = '{0, 0, 16'h3000, 1'b0, 1'b1, 15'h0000};
        rst_n   = 1'b0;
        bp_en   = 1'b1;
        bp_addr = 15'h0000;
        sb_reset();
        #20;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (bp_hit !== 1'b1 || imem_req !== 1'b0)
            $display("[TB] FAIL bp_reset_exit: got hit %b req %b expected 1 0", bp_hit, imem_req); else n_pass++;
        bp_resume = 1'b1;
        @(posedge clk); #1;
        bp_resume = 1'b0;
        bp_addr   = 15'h0002;
        n_checks++; if (bp_hit !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 15'h0000)
            $display("[TB] FAIL bp_reset_resume: got hit %b req %b addr %h expected 0 1 0000", bp_hit, imem_req, imem_addr); else n_pass++;
        run_instr(s);
        n_checks++; if (bp_hit !== 1'b0 || imem_req !== 1'b1 || pc !== model_pc)
            $display("[TB] FAIL bp_pass: got hit %b req %b pc %h expected 0 1 %h", bp_hit, imem_req, pc, model_pc); else n_pass++;
        run_instr(s);
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (bp_hit !== 1'b1 || imem_req !== 1'b0 || pc !== 15'h0002)
            $display("[TB] FAIL bp_hit: got hit %b req %b pc %h expected 1 0 0002", bp_hit, imem_req, pc); else n_pass++;
        bp_resume = 1'b1;
        @(posedge clk); #1;
        bp_resume = 1'b0;
        n_checks++; if (bp_hit !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 15'h0002)
            $display("[TB] FAIL bp_resume: got hit %b req %b addr %h expected 0 1 0002", bp_hit, imem_req, imem_addr); else n_pass++;
        run_instr(s);
        n_checks++; if (obs_addr !== exp_addr || obs_ipc !== exp_ipc)
            $display("[TB] FAIL bp_refetch: got %h@%h expected %h@%h", obs_addr, obs_ipc, exp_addr, exp_ipc); else n_pass++;
        bp_en = 1'b0;
    endtask
`endif

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_sequential();
        test_jump();
        test_wrap();
        test_stall();
        test_reset_in_hold();
`ifdef BREAKPOINT_EN
        test_breakpoint();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
